// File: rtl/controle_execucao.sv
// controle_execucao -- run-control sequencer for the single-cycle RISC-V core.
//
// Gates PC advancement (pc_en) so the core can be halted, run freely or
// single-stepped. It writes program words into instruction memory while the
// core is halted, stops on a single word-address breakpoint, and counts
// committed instructions.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (accepted when both high at clk edge)
//   cmd_op               0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 LOAD, 5 SETBP, 6 CLRBP, 7 reserved
//   cmd_addr, cmd_data   word address (LOAD/SETBP) and instruction word (LOAD)
//   pc                   current PC from the datapath
//   pc_en                PC register update enable (combinational)
//   imem_we/addr/wdata   registered instruction-memory write port
//   halted               high while halted
//   bp_hit               sticky: execution stopped on the breakpoint
//   cmd_err              one-cycle pulse: command rejected while running
//   instr_count          committed-instruction counter (wraps)
module controle_execucao #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [31:0]       pc,
  output logic              pc_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              halted,
  output logic              bp_hit,
  output logic              cmd_err,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_LOAD = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_RUN   = 3'd1,
    OP_HALT  = 3'd2,
    OP_STEP  = 3'd3,
    OP_LOAD  = 3'd4,
    OP_SETBP = 3'd5,
    OP_CLRBP = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  state_e              state_q, state_d;
  logic                bp_en_q, bp_en_d;
  logic [ADDR_W-1:0]   bp_addr_q, bp_addr_d;
  logic                bp_skip_q, bp_skip_d;
  logic                bp_hit_q, bp_hit_d;
  logic                cmd_err_q, cmd_err_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                bp_match;

  // Only the word index of the PC is compared; the remaining bits are unused.
  logic                pc_unused;
  assign pc_unused = ^{pc[31:ADDR_W+2], pc[1:0]};

  assign cmd_ready = (state_q == S_HALT) || (state_q == S_RUN);
  assign accept    = cmd_valid && cmd_ready;

  // bp_skip masks the breakpoint for the first instruction after a resume so
  // that a run started on the breakpoint address makes progress.
  assign bp_match = (state_q == S_RUN) && bp_en_q && !bp_skip_q &&
                    (pc[ADDR_W+1:2] == bp_addr_q);

  assign pc_en = ((state_q == S_RUN) && !bp_match) || (state_q == S_STEP);

  assign halted      = (state_q == S_HALT);
  assign bp_hit      = bp_hit_q;
  assign cmd_err     = cmd_err_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign instr_count = cnt_q;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d      = state_q;
    bp_en_d      = bp_en_q;
    bp_addr_d    = bp_addr_q;
    bp_skip_d    = bp_skip_q;
    bp_hit_d     = bp_hit_q;
    cmd_err_d    = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cnt_d        = cnt_q;

    if (pc_en) begin
      cnt_d     = cnt_q + CNT_W'(1);
      bp_skip_d = 1'b0;
    end

    unique case (state_q)
      S_HALT: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_RUN: begin
              state_d   = S_RUN;
              bp_skip_d = 1'b1;
              bp_hit_d  = 1'b0;
            end
            OP_STEP: begin
              state_d  = S_STEP;
              bp_hit_d = 1'b0;
            end
            OP_LOAD: begin
              state_d      = S_LOAD;
              imem_we_d    = 1'b1;
              imem_addr_d  = cmd_addr;
              imem_wdata_d = cmd_data;
            end
            OP_SETBP: begin
              bp_addr_d = cmd_addr;
              bp_en_d   = 1'b1;
            end
            OP_CLRBP: bp_en_d = 1'b0;
            default: ;
          endcase
        end
      end
      S_LOAD: state_d = S_HALT;
      S_STEP: state_d = S_HALT;
      S_RUN: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_HALT: state_d = S_HALT;
            OP_SETBP: begin
              bp_addr_d = cmd_addr;
              bp_en_d   = 1'b1;
            end
            OP_CLRBP: bp_en_d = 1'b0;
            OP_LOAD, OP_STEP: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
        // The breakpoint takes priority over a concurrent HALT command.
        if (bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset clears imem_we at once, even mid-LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HALT;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= '0;
      bp_skip_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      bp_en_q      <= bp_en_d;
      bp_addr_q    <= bp_addr_d;
      bp_skip_q    <= bp_skip_d;
      bp_hit_q     <= bp_hit_d;
      cmd_err_q    <= cmd_err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_controle_execucao.sv
// Directed testbench for controle_execucao. Two instances share all stimulus:
// u_dut uses the default 32-bit counter, u_dut4 a 4-bit counter for wrap tests.
// The bench drives pc like the datapath would: +4 after every pc_en cycle.
module tb_controle_execucao;

  localparam int ADDR_W = 6;

  localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, HALT = 3'd2, STEP = 3'd3,
                         LOAD = 3'd4, SETBP = 3'd5, CLRBP = 3'd6;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_data;
  logic [31:0]       pc;

  logic              cmd_ready, pc_en, imem_we, halted, bp_hit, cmd_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       instr_count;

  logic              cmd_ready4, pc_en4, imem_we4, halted4, bp_hit4, cmd_err4;
  logic [ADDR_W-1:0] imem_addr4;
  logic [31:0]       imem_wdata4;
  logic [3:0]        instr_count4;

  int vectors;
  int miscompares;

  controle_execucao #(.ADDR_W(ADDR_W), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .pc(pc),
    .pc_en(pc_en), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .halted(halted), .bp_hit(bp_hit),
    .cmd_err(cmd_err), .instr_count(instr_count)
  );

  controle_execucao #(.ADDR_W(ADDR_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .pc(pc),
    .pc_en(pc_en4), .imem_we(imem_we4), .imem_addr(imem_addr4),
    .imem_wdata(imem_wdata4), .halted(halted4), .bp_hit(bp_hit4),
    .cmd_err(cmd_err4), .instr_count(instr_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample pc_en before the edge, then advance pc like the datapath.
  task automatic tick();
    logic en_s;
    #1;
    en_s = pc_en;
    @(posedge clk);
    #1;
    if (en_s) pc = pc + 32'd4;
  endtask

  task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = NOP;
    cmd_addr = '0;
    cmd_data = '0;
    pc = 32'd0;

    // Reset values
    #2;
    check_idle("rst");
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Test 1: LOAD produces exactly one write cycle
    send(LOAD, 6'd3, 32'h00500093);
    check("ld_we", 32'(imem_we), 32'd1);
    check("ld_addr", 32'(imem_addr), 32'd3);
    check("ld_data", imem_wdata, 32'h00500093);
    check("ld_pc_en", 32'(pc_en), 32'd0);
    check("ld_ready", 32'(cmd_ready), 32'd0);
    tick();
    check_idle("ld_done");

    // Test 2: three single steps from pc=0
    for (int i = 0; i < 3; i++) begin
      send(STEP, '0, '0);
      check("st_pc_en", 32'(pc_en), 32'd1);
      check("st_halted", 32'(halted), 32'd0);
      tick();
      check_idle("st_done");
    end
    check("st_count", instr_count, 32'd3);
    check("st_pc", pc, 32'd12);

    // Test 3: breakpoint at word 4, run from pc=0
    pc = 32'd0;
    send(SETBP, 6'd4, '0);
    send(RUN, '0, '0);
    for (int i = 0; i < 20 && pc_en; i++) tick();
    check("bp_pc", pc, 32'h10);
    check("bp_pc_en", 32'(pc_en), 32'd0);
    check("bp_count_pre", instr_count, 32'd7);
    tick();
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_count", instr_count, 32'd7);

    // Test 4: resume on the breakpoint address, then HALT command
    send(RUN, '0, '0);
    check("rs_bp_hit", 32'(bp_hit), 32'd0);
    check("rs_pc_en", 32'(pc_en), 32'd1);
    tick();
    check("rs_pc", pc, 32'h14);
    check("rs_count", instr_count, 32'd8);
    tick();
    send(HALT, '0, '0);
    check_idle("rs_halt");
    check("rs_halt_count", instr_count, 32'd10);
    check("rs_halt_pc", pc, 32'h1c);

    // Test 5: LOAD and STEP rejected while running
    send(RUN, '0, '0);
    send(LOAD, 6'd5, 32'hdeadbeef);
    check("rj_err", 32'(cmd_err), 32'd1);
    check("rj_we", 32'(imem_we), 32'd0);
    check("rj_running", 32'(pc_en), 32'd1);
    tick();
    check("rj_err_pulse", 32'(cmd_err), 32'd0);
    send(STEP, '0, '0);
    check("rj_step_err", 32'(cmd_err), 32'd1);
    check("rj_step_halted", 32'(halted), 32'd0);
    send(HALT, '0, '0);
    check("rj_count", instr_count, 32'd14);

    // HALT command coinciding with the breakpoint: breakpoint wins
    pc = 32'hc;
    send(RUN, '0, '0);
    tick();
    check("hb_pc", pc, 32'h10);
    send(HALT, '0, '0);
    check("hb_halted", 32'(halted), 32'd1);
    check("hb_bp_hit", 32'(bp_hit), 32'd1);
    check("hb_count", instr_count, 32'd15);

    // CLRBP: running through word 4 no longer stops
    send(CLRBP, '0, '0);
    pc = 32'hc;
    send(RUN, '0, '0);
    tick();
    tick();
    check("cb_pc", pc, 32'h14);
    check("cb_pc_en", 32'(pc_en), 32'd1);
    send(HALT, '0, '0);

    // Reset asserted during the LOAD cycle
    send(LOAD, 6'd7, 32'h00001234);
    check("rl_we", 32'(imem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_idle("rl");
    check("rl_addr", 32'(imem_addr), 32'd0);
    check("rl_data", imem_wdata, 32'd0);
    check("rl_count", instr_count, 32'd0);
    check("rl_bp_hit", 32'(bp_hit), 32'd0);
    check("rl_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Test 6: 4-bit counter wraps 15 -> 0 after 16 steps
    pc = 32'd0;
    for (int i = 0; i < 15; i++) begin
      send(STEP, '0, '0);
      tick();
    end
    check("wr_count15", 32'(instr_count4), 32'd15);
    send(STEP, '0, '0);
    tick();
    check("wr_count0", 32'(instr_count4), 32'd0);
    check("wr_count32", instr_count, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
